// File: rtl/afu_pkg.sv
// Shared BRAM geometry and reader FSM encoding for the AFU datapath blocks.
package afu_pkg;

  localparam int BRAM_WORDS      = 512;
  localparam int BRAM_ADDR_WIDTH = $clog2(BRAM_WORDS);
  localparam int BRAM_DATA_WIDTH = 64;
  localparam int BRAM_RD_LATENCY = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/stream_fifo.sv
// Small show-ahead FIFO: pop_data is the head entry whenever empty is low.
// A push and a pop in the same cycle are accepted even when full.
module stream_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q];
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Reads `length` consecutive BRAM words (address wraps) and streams them over valid/ready.
// Define BRAM_STREAM_CHECKSUM_EN to add a checksum output summing the accepted beats.
module bram_stream_reader
  import afu_pkg::*;
#(
  parameter int DATA_WIDTH = BRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
  parameter int RD_LATENCY = BRAM_RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  input  logic [DATA_WIDTH-1:0] bram_rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready
`ifdef BRAM_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);
  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W      = CNT_W + 2;
  localparam int LEN_W      = ADDR_WIDTH + 1;

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [RD_LATENCY-1:0] lat_sr_q, lat_sr_d;
  logic [LEN_W-1:0]      rd_rem_q, rd_rem_d;
  logic [LEN_W-1:0]      beat_rem_q, beat_rem_d;

  logic                  accept, issue, pop;
  logic                  fifo_push, fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [CRD_W-1:0]      inflight;

  stream_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(bram_rd_data),
    .pop      (pop),
    .pop_data (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign accept       = (state_q == ST_IDLE) && start;
  assign out_valid    = !fifo_empty;
  assign pop          = out_valid && out_ready;
  assign out_last     = out_valid && (beat_rem_q == LEN_W'(1));
  assign out_data     = out_valid ? fifo_dout : '0;
  assign bram_rd_addr = rd_addr_q;
  // rd_vld_q marks the address register; lat_sr_q then counts off the BRAM latency.
  assign fifo_push    = lat_sr_q[RD_LATENCY-1] && (!fifo_full || pop);
  assign inflight     = CRD_W'(rd_vld_q) + CRD_W'($countones(lat_sr_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (length == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (issue && (rd_rem_q == LEN_W'(1))) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && out_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Every read in flight already owns a FIFO slot, so the FIFO can never overflow.
  always_comb begin
    busy  = (state_q != ST_IDLE);
    done  = (state_q == ST_DONE);
    issue = (state_q == ST_RUN) &&
            ((inflight + CRD_W'(fifo_count) - CRD_W'(pop)) < CRD_W'(FIFO_DEPTH));
  end

  always_comb begin
    next_addr_d = next_addr_q;
    rd_addr_d   = rd_addr_q;
    rd_rem_d    = rd_rem_q;
    beat_rem_d  = beat_rem_q;
    rd_vld_d    = issue;
    lat_sr_d    = RD_LATENCY'({lat_sr_q, rd_vld_q});
    if (accept) begin
      next_addr_d = start_addr;
      rd_rem_d    = length;
      beat_rem_d  = length;
    end
    if (issue) begin
      rd_addr_d   = next_addr_q;
      next_addr_d = next_addr_q + ADDR_WIDTH'(1);
      rd_rem_d    = rd_rem_q - LEN_W'(1);
    end
    if (pop) beat_rem_d = beat_rem_q - LEN_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_addr_q <= '0;
      rd_addr_q   <= '0;
      rd_vld_q    <= 1'b0;
      lat_sr_q    <= '0;
      rd_rem_q    <= '0;
      beat_rem_q  <= '0;
    end else begin
      next_addr_q <= next_addr_d;
      rd_addr_q   <= rd_addr_d;
      rd_vld_q    <= rd_vld_d;
      lat_sr_q    <= lat_sr_d;
      rd_rem_q    <= rd_rem_d;
      beat_rem_q  <= beat_rem_d;
    end
  end

`ifdef BRAM_STREAM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (accept)   sum_d = '0;
    else if (pop) sum_d = sum_q + out_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: queue-based reference model of the beat
// stream plus directed literal expectations; define BRAM_STREAM_CHECKSUM_EN to test checksum.
module tb_bram_stream_reader;
  localparam int DW    = 64;
  localparam int AW    = 9;
  localparam int LW    = AW + 1;
  localparam int LAT   = 3;
  localparam int WORDS = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic          busy, done;
  logic [AW-1:0] bram_rd_addr;
  logic [DW-1:0] bram_rd_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
`ifdef BRAM_STREAM_CHECKSUM_EN
  logic [DW-1:0] checksum;
  logic [DW-1:0] done_checksum;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bram_stream_reader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RD_LATENCY(LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_addr  (start_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .bram_rd_addr(bram_rd_addr),
    .bram_rd_data(bram_rd_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready)
`ifdef BRAM_STREAM_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  // BRAM with a LAT-cycle read pipeline: address in cycle k, data valid in cycle k+LAT.
  logic [DW-1:0] mem  [WORDS];
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= mem[bram_rd_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_rd_data = pipe[LAT-1];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0b required=%0b t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: the expected beats {last, data} of the current transfer.
  logic [DW:0]   exp_q[$];
  logic [DW:0]   exp_ent;
  logic [DW-1:0] exp_sum;
  logic [DW-1:0] got_q[$];
  int            cyc = 0;
  int            accept_cyc = 0;
  int            first_beat_rel = -1;
  int            done_rel = -1;
  int            done_count = 0;
  int            ready_prob = 100;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(99) < ready_prob);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk1("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, prev_data);
        chk1("hold_last", out_last, prev_last);
      end
      if (out_last && !out_valid) chk1("last_without_valid", out_last, 1'b0);
      if (out_valid && exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: actual data=%0h required no beat t=%0t", out_data, $time);
      end else if (out_valid && out_ready) begin
        exp_ent = exp_q.pop_front();
        chk("beat_data", out_data, exp_ent[DW-1:0]);
        chk1("beat_last", out_last, exp_ent[DW]);
        got_q.push_back(out_data);
        if (first_beat_rel < 0) first_beat_rel = cyc - accept_cyc;
      end
      if (done) begin
        done_count++;
        done_rel = cyc - accept_cyc;
        chk_int("done_all_beats_seen", exp_q.size(), 0);
`ifdef BRAM_STREAM_CHECKSUM_EN
        done_checksum = checksum;
        chk("checksum_model", checksum, exp_sum);
`endif
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic do_xfer(input logic [AW-1:0] a, input logic [AW:0] n, input int rdy, input bit poke);
    int idx;
    ready_prob = rdy;
    @(posedge clk);
    #1;
    exp_q.delete();
    got_q.delete();
    exp_sum        = '0;
    first_beat_rel = -1;
    done_rel       = -1;
    done_count     = 0;
    for (int i = 0; i < int'(n); i++) begin
      idx = (int'(a) + i) % WORDS;
      exp_q.push_back({(i == int'(n) - 1), mem[idx]});
      exp_sum = exp_sum + mem[idx];
    end
    start      = 1'b1;
    start_addr = a;
    length     = n;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    start      = 1'b0;
    chk1("busy_after_accept", busy, 1'b1);
    for (int t = 0; t < 5000 && done_count == 0; t++) begin
      @(posedge clk);
      #1;
      if (poke && t == 2) begin
        start      = 1'b1;
        start_addr = AW'($urandom_range(WORDS - 1));
        length     = LW'($urandom_range(1, 20));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk_int("done_pulses", done_count, 1);
    chk_int("beat_count", got_q.size(), int'(n));
    chk1("busy_after_done", busy, 1'b0);
    chk1("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    for (int i = 0; i < WORDS; i++) mem[i] = DW'(i);
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    chk("rst_rd_addr", DW'(bram_rd_addr), '0);
    chk("rst_out_data", out_data, '0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Directed: BRAM[i]=i, start 0, length 4, ready high.
    do_xfer(AW'(0), LW'(4), 100, 1'b0);
    chk_int("first_beat_rel", first_beat_rel, 5);
    chk_int("done_rel", done_rel, 9);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("seq0_beat", got_q[i], DW'(i));

    // Directed: address wrap 510,511,0,1.
    do_xfer(AW'(510), LW'(4), 100, 1'b0);
    if (got_q.size() == 4) begin
      chk("wrap_beat0", got_q[0], DW'(510));
      chk("wrap_beat1", got_q[1], DW'(511));
      chk("wrap_beat2", got_q[2], DW'(0));
      chk("wrap_beat3", got_q[3], DW'(1));
    end

    // Directed: zero length gives only a done pulse, in the cycle right after the start cycle.
    do_xfer(AW'(17), LW'(0), 100, 1'b0);
    chk_int("len0_done_rel", done_rel, 0);
    chk_int("len0_first_beat", first_beat_rel, -1);

`ifdef BRAM_STREAM_CHECKSUM_EN
    do_xfer(AW'(1), LW'(4), 100, 1'b0);
    chk("checksum_1234", done_checksum, DW'(10));
`endif

    // Full-memory transfer with random data, 50% ready and a start pulse during RUN.
    for (int i = 0; i < WORDS; i++) mem[i] = {$urandom(), $urandom()};
    do_xfer(AW'($urandom_range(WORDS - 1)), LW'(512), 50, 1'b1);

    // Reset in the middle of a transfer.
    ready_prob = 50;
    @(posedge clk);
    #1;
    done_count = 0;
    exp_q.delete();
    for (int i = 0; i < 200; i++) exp_q.push_back({(i == 199), mem[(100 + i) % WORDS]});
    start      = 1'b1;
    start_addr = AW'(100);
    length     = LW'(200);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_out_valid", out_valid, 1'b0);
    chk1("abort_out_last", out_last, 1'b0);
    chk("abort_rd_addr", DW'(bram_rd_addr), '0);
    chk("abort_out_data", out_data, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk_int("abort_no_done", done_count, 0);
    chk1("abort_stays_idle", busy, 1'b0);

    do_xfer(AW'(300), LW'(40), 70, 1'b1);

    for (int k = 0; k < 6; k++) begin
      do_xfer(AW'($urandom_range(WORDS - 1)), LW'($urandom_range(40)),
              int'($urandom_range(30, 100)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_WIDTH, 64, BRAM word width; ADDR_WIDTH, 9, BRAM address width; RD_LATENCY, 3, cycles from bram_rd_addr to valid bram_rd_data.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-003 start in 1 request a transfer; accepted only in IDLE.
REQ-004 start_addr in ADDR_WIDTH first BRAM word.
REQ-005 length in ADDR_WIDTH+1 word count, 0..2^ADDR_WIDTH.
REQ-006 busy out 1 high from the start-accept cycle until done.
REQ-007 done out 1 one-cycle pulse when the transfer completes.
REQ-008 bram_rd_addr out ADDR_WIDTH BRAM read address, registered.
REQ-009 bram_rd_data in DATA_WIDTH BRAM read data.
REQ-010 out_valid, out_data (DATA_WIDTH), out_last out; out_ready in: valid/ready stream.

Function
REQ-011 SHALL implement FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-012 IDLE + start + length>0: latch start_addr/length, go to RUN; start outside IDLE SHALL be ignored.
REQ-013 IDLE + start + length==0: go to DONE; no read issued and no beat produced.
REQ-014 RUN: issue one read per cycle while credit available; credit = inflight + fifo_count - pop < FIFO_DEPTH, where FIFO_DEPTH = RD_LATENCY+2.
REQ-015 Read address SHALL increment by 1 per issue and wrap modulo 2^ADDR_WIDTH (511 -> 0).
REQ-016 Issued reads SHALL be tracked by a RD_LATENCY-deep valid shift register; each bit exiting writes bram_rd_data into the FIFO.
REQ-017 RUN -> DRAIN when the final read is issued; DRAIN -> DONE when the final beat is accepted (out_valid & out_ready & out_last).
REQ-018 DONE: done=1 for exactly one cycle, busy=0 in the following cycle, return to IDLE.
REQ-019 Stream SHALL deliver exactly length beats in address order; out_last=1 only on the final beat.
REQ-020 out_data/out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-021 With out_ready held high, the first beat SHALL appear RD_LATENCY+2 cycles after the start-accept edge and beats SHALL then be back-to-back.
REQ-022 FIFO SHALL never overflow under any out_ready pattern; a push and pop in the same cycle on a full FIFO SHALL be legal.

Reset
REQ-023 rst SHALL force IDLE, clear FIFO, shift register, counters; busy=0, done=0, out_valid=0, out_last=0, bram_rd_addr=0, out_data=0.
REQ-024 rst mid-transfer SHALL abort it with no done pulse; in-flight BRAM data SHALL be discarded.

Configuration
REQ-025 Macro BRAM_STREAM_CHECKSUM_EN: when defined, add output checksum (DATA_WIDTH), the modulo-2^DATA_WIDTH sum of accepted beats, cleared on start accept, valid with done.
REQ-026 When undefined, the checksum port and adder SHALL not exist; all other behaviour is identical.

Structure
REQ-027 Shared package afu_pkg SHALL hold BRAM_WORDS, BRAM_ADDR_WIDTH, BRAM_DATA_WIDTH, BRAM_RD_LATENCY and the FSM state enum.
REQ-028 FIFO SHALL be a separate sub-module stream_fifo (parameters width, depth; outputs full, empty, count).

Verification
REQ-029 start_addr=0, length=4, out_ready=1, BRAM[i]=i -> beats 0,1,2,3 on cycles 5..8 after accept, out_last on 3, done one cycle later.
REQ-030 start_addr=510, length=4 -> beats from addresses 510,511,0,1.
REQ-031 length=0 -> no out_valid, done pulse one cycle after accept.
REQ-032 length=512, random out_ready (50%) -> 512 beats in order, no loss or duplication, data stable while stalled.
REQ-033 start pulsed during RUN -> ignored; rst asserted mid-transfer -> all outputs reset, no done; new transfer then completes normally.
REQ-034 BRAM_STREAM_CHECKSUM_EN defined, data 1,2,3,4 -> checksum=10 at done.
